// File: rtl/sr_pkg.sv
// Shared command codes and controller state encoding for the SR latch command stage.
package sr_pkg;

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_RESET = 2'b01;
    localparam logic [1:0] SR_SET   = 2'b10;
    localparam logic [1:0] SR_BAD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_REL = 2'd2
    } sr_ctrl_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer for one raw pushbutton.
module btn_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        // Any sample matching the stable level restarts the run, so glitches never accumulate.
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/sr_button_ctrl.sv
// Turns debounced SET/RESET buttons into single-cycle, E-qualified SR latch commands.
module sr_button_ctrl
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_btn,
    input  logic       reset_btn,
    output logic [1:0] sr,
    output logic       E,
    output logic       busy
);

    logic           set_st;
    logic           rst_st;
    sr_ctrl_state_t state_q;
    logic [1:0]     sr_q;
    logic           e_q;
    logic           busy_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_set (
        .clk    (clk),
        .rst    (rst),
        .raw    (set_btn),
        .stable (set_st)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_rst (
        .clk    (clk),
        .rst    (rst),
        .raw    (reset_btn),
        .stable (rst_st)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= SR_HOLD;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // RESET takes priority so the forbidden 2'b11 code can never be formed.
                    if (set_st || rst_st) begin
                        state_q <= PULSE;
                        sr_q    <= rst_st ? SR_RESET : SR_SET;
                        e_q     <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                PULSE: begin
                    state_q <= WAIT_REL;
                    sr_q    <= SR_HOLD;
                    e_q     <= 1'b0;
                end
                WAIT_REL: begin
                    if (!set_st && !rst_st) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sr_q    <= SR_HOLD;
                    e_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sr   = sr_q;
    assign E    = e_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sr_button_ctrl.sv
// Directed bench for sr_button_ctrl with DEB_CYCLES=4: latency, bounce, priority and reset cases.
module tb_sr_button_ctrl;

    localparam int DEB = 4;
    localparam int CNT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_btn;
    logic       reset_btn;
    logic [1:0] sr;
    logic       E;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc, pulses, first_pulse, first_sr, busy_rise, busy_fall;

    always #5 clk = ~clk;

    sr_button_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_btn   (set_btn),
        .reset_btn (reset_btn),
        .sr        (sr),
        .E         (E),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clr();
        cyc = 0; pulses = 0; first_pulse = 0; first_sr = 0; busy_rise = 0; busy_fall = 0;
    endtask

    // One rising edge; outputs sampled 1 time unit later, invariants checked every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("inv_no_11", int'(sr != 2'b11), 1);
        chk("inv_e0_hold", int'(E || (sr == 2'b00)), 1);
        if (E) begin
            pulses++;
            if (first_pulse == 0) begin
                first_pulse = cyc;
                first_sr    = int'(sr);
            end
        end
        if (busy && busy_rise == 0) busy_rise = cyc;
        if (!busy && busy_rise != 0 && busy_fall == 0) busy_fall = cyc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int bounce [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
        clr();

        // Reset held with both buttons pressed
        rst = 1'b1; set_btn = 1'b1; reset_btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_sr", int'(sr), 0);
            chk("rst_E", int'(E), 0);
            chk("rst_busy", int'(busy), 0);
        end
        rst = 1'b0; reset_btn = 1'b0;
        clr();
        run(12);
        chk("post_rst_first", first_pulse, 7);
        chk("post_rst_sr", first_sr, 2);
        chk("post_rst_pulses", pulses, 1);
        set_btn = 1'b0;
        run(12);
        chk("post_rst_idle", int'(busy), 0);

        // Clean set press held 20 cycles
        clr();
        set_btn = 1'b1;
        run(20);
        set_btn = 1'b0;
        run(12);
        chk("set_first", first_pulse, 7);
        chk("set_sr", first_sr, 2);
        chk("set_pulses", pulses, 1);
        chk("set_busy_rise", busy_rise, 7);
        chk("set_busy_fall", busy_fall, 27);

        // Bounce: high runs of 3 never reach the debounce threshold
        clr();
        for (int i = 0; i < 8; i++) begin
            set_btn = bounce[i][0];
            tick();
        end
        set_btn = 1'b0;
        run(12);
        chk("bounce_pulses", pulses, 0);
        chk("bounce_busy", busy_rise, 0);

        // Simultaneous press: RESET wins
        clr();
        set_btn = 1'b1; reset_btn = 1'b1;
        run(15);
        chk("both_first", first_pulse, 7);
        chk("both_sr", first_sr, 1);
        set_btn = 1'b0;
        run(15);
        chk("both_pulses", pulses, 1);
        chk("both_busy_held", int'(busy), 1);
        reset_btn = 1'b0;
        run(10);
        chk("both_busy_rel", int'(busy), 0);

        // RESET held, then SET pressed while held is ignored
        clr();
        reset_btn = 1'b1;
        run(12);
        chk("held_sr", first_sr, 1);
        set_btn = 1'b1;
        run(10);
        set_btn = 1'b0;
        run(10);
        chk("held_pulses", pulses, 1);
        chk("held_busy", int'(busy), 1);
        reset_btn = 1'b0;
        run(10);
        chk("held_rel_busy", int'(busy), 0);
        clr();
        set_btn = 1'b1;
        run(12);
        chk("held_next_first", first_pulse, 7);
        chk("held_next_sr", first_sr, 2);
        chk("held_next_pulses", pulses, 1);
        set_btn = 1'b0;
        run(12);

        // Reset at debounce count 2 restarts the whole path
        clr();
        set_btn = 1'b1;
        run(4);
        rst = 1'b1;
        tick();
        chk("mid_rst_E", int'(E), 0);
        chk("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        cyc = 0;
        run(12);
        chk("mid_rst_first", first_pulse, 7);
        chk("mid_rst_sr", first_sr, 2);
        chk("mid_rst_pulses", pulses, 1);
        set_btn = 1'b0;
        run(12);
        chk("mid_rst_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
